// File: rtl/conv2d_seq.sv
// Sequential 2-D convolution: one MAC walks every filter tap of every valid output window.
// Optional CONV2D_SAT_EN: clamp results to 2^OW-1 instead of wrapping to the low OW bits.
module conv2d_seq #(
   parameter int DW      = 8,
   parameter int IN_DIM  = 4,
   parameter int K_DIM   = 3,
   parameter int OW      = 8,
   localparam int OUT_DIM = IN_DIM - K_DIM + 1,
   localparam int IN_N    = IN_DIM * IN_DIM,
   localparam int OUT_N   = OUT_DIM * OUT_DIM,
   localparam int AW      = (IN_N > 1) ? $clog2(IN_N) : 1,
   localparam int OAW     = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld_en,
   input  logic           ld_sel,
   input  logic [AW-1:0]  ld_addr,
   input  logic [DW-1:0]  ld_data,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           out_valid,
   output logic [OAW-1:0] out_addr,
   output logic [OW-1:0]  out_data,
   output logic [2:0]     state
);
   localparam int K_N  = K_DIM * K_DIM;
   localparam int KAW  = (K_N > 1) ? $clog2(K_N) : 1;
   localparam int CW   = $clog2(IN_DIM + 1);
   localparam int ACCW = 2 * DW + $clog2(K_N);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MAC  = 3'd1,
      S_EMIT = 3'd2,
      S_DONE = 3'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   r_q, r_d, c_q, c_d, kr_q, kr_d, kc_q, kc_d;
   logic [ACCW-1:0] acc_q, acc_d, acc_sum;
   logic            busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
   logic [OAW-1:0]  out_addr_q, out_addr_d;
   logic [OW-1:0]   out_data_q, out_data_d, res_val;
   logic [DW-1:0]   img_q [IN_N];
   logic [DW-1:0]   img_d [IN_N];
   logic [DW-1:0]   flt_q [K_N];
   logic [DW-1:0]   flt_d [K_N];
   logic [2*DW-1:0] prod;
   int              img_i, flt_i, out_i;

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      c_d         = c_q;
      kr_d        = kr_q;
      kc_d        = kc_q;
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      img_d       = img_q;
      flt_d       = flt_q;

      img_i   = (int'(r_q) + int'(kr_q)) * IN_DIM + int'(c_q) + int'(kc_q);
      flt_i   = int'(kr_q) * K_DIM + int'(kc_q);
      out_i   = int'(r_q) * OUT_DIM + int'(c_q);
      prod    = {{DW{1'b0}}, img_q[AW'(img_i)]} * {{DW{1'b0}}, flt_q[KAW'(flt_i)]};
      acc_sum = acc_q + ACCW'(prod);
`ifdef CONV2D_SAT_EN
      res_val = ((acc_sum >> OW) != '0) ? {OW{1'b1}} : OW'(acc_sum);
`else
      res_val = OW'(acc_sum);
`endif

      case (state_q)
         S_IDLE: begin
            if (ld_en) begin
               if (!ld_sel && int'(ld_addr) < IN_N)
                  img_d[ld_addr] = ld_data;
               else if (ld_sel && int'(ld_addr) < K_N)
                  flt_d[KAW'(ld_addr)] = ld_data;
            end
            if (start) begin
               state_d = S_MAC;
               acc_d   = '0;
               r_d     = '0;
               c_d     = '0;
               kr_d    = '0;
               kc_d    = '0;
            end
         end
         S_MAC: begin
            acc_d = acc_sum;
            if (kc_q == CW'(K_DIM - 1)) begin
               kc_d = '0;
               if (kr_q == CW'(K_DIM - 1)) begin
                  // last tap: present the finished sum on the next cycle
                  kr_d        = '0;
                  state_d     = S_EMIT;
                  out_valid_d = 1'b1;
                  out_addr_d  = OAW'(out_i);
                  out_data_d  = res_val;
               end else begin
                  kr_d = kr_q + CW'(1);
               end
            end else begin
               kc_d = kc_q + CW'(1);
            end
         end
         S_EMIT: begin
            acc_d   = '0;
            state_d = S_MAC;
            if (c_q == CW'(OUT_DIM - 1)) begin
               c_d = '0;
               if (r_q == CW'(OUT_DIM - 1)) begin
                  r_d     = '0;
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  r_d = r_q + CW'(1);
               end
            end else begin
               c_d = c_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_MAC) || (state_d == S_EMIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         r_q         <= '0;
         c_q         <= '0;
         kr_q        <= '0;
         kc_q        <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         for (int i = 0; i < IN_N; i++) img_q[i] <= '0;
         for (int i = 0; i < K_N; i++)  flt_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         c_q         <= c_d;
         kr_q        <= kr_d;
         kc_q        <= kc_d;
         acc_q       <= acc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         img_q       <= img_d;
         flt_q       <= flt_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign state     = state_q;
endmodule

// File: doc/conv2d_seq.md
# conv2d_seq

Parametrised sequential 2-D convolution engine: a single multiply-accumulate datapath computes every valid output of an IN_DIM×IN_DIM image convolved with a K_DIM×K_DIM filter. It replaces the fixed 4×4/3×3 array wiring in the top-level. Image and filter are loaded through a write port, a start/done handshake runs the job, and results stream out one per output-valid strobe to the display or a result store.

## Interface
- DW, 8, image/filter element width (unsigned)
- IN_DIM, 4, image side length
- K_DIM, 3, filter side length; 1 ≤ K_DIM ≤ IN_DIM
- OW, 8, output width; OUT_DIM = IN_DIM−K_DIM+1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ld_en  in  1  write strobe for image/filter storage
- ld_sel  in  1  0 = image, 1 = filter
- ld_addr  in  clog2(IN_DIM²)  row-major element index
- ld_data  in  DW  element value
- start  in  1  job request, sampled in IDLE only
- busy  out  1  high in MAC and EMIT
- done  out  1  one-cycle pulse at job end
- out_valid  out  1  result strobe
- out_addr  out  clog2(OUT_DIM²) (min 1)  row-major output index
- out_data  out  OW  result value
- state  out  3  FSM state code (debug)

## Operation
- Storage: IN_DIM² image registers and K_DIM² filter registers, all cleared by rst.
- Load: in IDLE, `ld_en` writes `ld_data` at `ld_addr` on the next edge.
  - Writes while busy or in DONE are ignored.
  - Filter writes with `ld_addr` ≥ K_DIM², and image writes with `ld_addr` ≥ IN_DIM², are ignored.
- FSM states: IDLE=0, MAC=1, EMIT=2, DONE=3.
  - IDLE→MAC on `start`: clears acc, output index (r,c)=(0,0), tap index (kr,kc)=(0,0).
  - MAC: each cycle acc += img[r+kr][c+kc] × flt[kr][kc]; tap advances kc-first. After tap (K_DIM−1,K_DIM−1) is accumulated → EMIT.
  - EMIT: one cycle with out_valid=1, out_addr=r·OUT_DIM+c, out_data=f(acc).
    - If not the last output: advance c-first, clear acc, → MAC.
    - After output (OUT_DIM−1,OUT_DIM−1): → DONE.
  - DONE: one cycle, done=1, → IDLE.
- Arithmetic: unsigned products 2·DW bits; acc width 2·DW+clog2(K_DIM²), never overflows.
  - f(acc) is the low OW bits of acc (wrap), unless saturation is configured (see Configuration).
- start while not in IDLE: ignored, never queued.
- start and ld_en asserted in the same IDLE cycle: the write lands on the same edge and the job uses the new value.
- rst asserted mid-job: immediate return to IDLE, all outputs and storage zeroed, partial job discarded with no done pulse.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_addr=0, out_data=0, state=0.
- E0 is the edge that samples start. MAC accumulates on edges E1..E(K_DIM²).
- Each output costs K_DIM²+1 cycles. Output n is valid during the cycle after edge E0+n·(K_DIM²+1)+K_DIM².
- Defaults give outputs at cycles 10, 20, 30, 40 after E0, done in cycle 41, IDLE from edge E41.
  - Next start is accepted at edge E41 at the earliest.
- out_addr and out_data are registered and change only when entering EMIT. out_valid is exactly one cycle per output.
- done is never coincident with out_valid.

## Configuration
- CONV2D_SAT_EN defined: out_data = min(acc, 2^OW−1).
- CONV2D_SAT_EN undefined: out_data = acc[OW−1:0] (wrap).
- No other behaviour differs between the two builds.

## Test plan
- Defaults; image 1..16 row-major, filter all 1; start → out_valid at cycles 10/20/30/40 with (addr,data)=(0,54),(1,63),(2,90),(3,99); done at cycle 41.
- Same image, filter with only center tap (addr 4) = 1 → outputs 6, 7, 10, 11.
- Image and filter all 255 → every out_data = 9 without CONV2D_SAT_EN and 255 with it.
- During a job, pulse start and write ld_data=0 to image addr 0 → results unchanged (54, 63, 90, 99), no second job runs, busy stays high throughout.
- Drop rst at cycle 15 of a job → outputs zero immediately, no done pulse. After reload and start, first result arrives exactly 10 cycles after E0.
- Parameters IN_DIM=5, K_DIM=2, image 1..25, filter all 1 → 16 outputs at 5-cycle spacing, first = 1+2+6+7 = 16, last = 19+20+24+25 = 88, done at cycle 81.
